// File: rtl/icache_sa.sv
// icache_sa: set-associative instruction cache with an AXI4 read master for line fills.
//
// Ports:
//   clk, reset               clock; asynchronous active-low reset
//   fetch_addr               instruction byte address
//   out_inst, icache_valid   32-bit instruction and hit indication (combinational)
//   flush                    invalidate-all request, level sampled every cycle
//   icache_err               one-cycle pulse after a fill that saw an error response
//   icache_m_axi_ar*         read-address channel (single WRAP burst per line fill)
//   icache_m_axi_r*          read-data channel; rid is ignored
//
// Lines are filled critical-word-first.
// Hits to any line other than the fill victim are served while a fill is in flight.
module icache_sa #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int SIZE_BYTES = 16384,
    parameter int LINE_WORDS = 8,
    parameter int WAYS       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [31:0]           out_inst,
    output logic                  icache_valid,
    input  logic                  flush,
    output logic                  icache_err,
    output logic [ID_WIDTH-1:0]   icache_m_axi_arid,
    output logic [ADDR_WIDTH-1:0] icache_m_axi_araddr,
    output logic [7:0]            icache_m_axi_arlen,
    output logic [2:0]            icache_m_axi_arsize,
    output logic [1:0]            icache_m_axi_arburst,
    output logic                  icache_m_axi_arlock,
    output logic [3:0]            icache_m_axi_arcache,
    output logic [2:0]            icache_m_axi_arprot,
    output logic                  icache_m_axi_arvalid,
    input  logic                  icache_m_axi_arready,
    input  logic [ID_WIDTH-1:0]   icache_m_axi_rid,
    input  logic [DATA_WIDTH-1:0] icache_m_axi_rdata,
    input  logic [1:0]            icache_m_axi_rresp,
    input  logic                  icache_m_axi_rlast,
    input  logic                  icache_m_axi_rvalid,
    output logic                  icache_m_axi_rready
);

    localparam int SETS     = SIZE_BYTES / (WAYS * LINE_WORDS * 8);
    localparam int OFF_W    = $clog2(LINE_WORDS);
    localparam int IDX_W    = $clog2(SETS);
    localparam int TAG_W    = ADDR_WIDTH - 3 - OFF_W - IDX_W;
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LINE_LSB = 3 + OFF_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [SETS-1:0]         valid_r    [WAYS];
    logic [WAY_W-1:0]        rr_r       [SETS];
    logic [TAG_W-1:0]        tag_mem_r  [WAYS][SETS];
    logic [DATA_WIDTH-1:0]   data_mem_r [WAYS][SETS*LINE_WORDS];
    logic [ADDR_WIDTH-4:0]   miss_addr_r;   // miss address without the byte-in-word bits
    logic [WAY_W-1:0]        victim_r;
    logic [OFF_W-1:0]        fill_off_r;
    logic                    err_r;
    logic                    flush_pend_r;
    logic                    err_pulse_r;

    logic [IDX_W-1:0]        fetch_idx_s;
    logic [OFF_W-1:0]        fetch_off_s;
    logic [TAG_W-1:0]        fetch_tag_s;
    logic [IDX_W-1:0]        miss_idx_s;
    logic [WAYS-1:0]         hit_vec_s;
    logic                    hit_s;
    logic [WAY_W-1:0]        hit_way_s;
    logic [WAY_W-1:0]        victim_s;
    logic [DATA_WIDTH-1:0]   word_s;
    logic                    start_fill_s;
    logic                    beat_s;
    logic                    last_s;
    logic                    beat_err_s;
    logic                    unused_s;

    assign fetch_idx_s  = fetch_addr[LINE_LSB +: IDX_W];
    assign fetch_off_s  = fetch_addr[3 +: OFF_W];
    assign fetch_tag_s  = fetch_addr[ADDR_WIDTH-1 -: TAG_W];
    assign miss_idx_s   = miss_addr_r[OFF_W +: IDX_W];
    assign start_fill_s = (state_r == IDLE) && !flush && !hit_s;
    assign beat_s       = (state_r == DATA) && icache_m_axi_rvalid;
    assign last_s       = beat_s && icache_m_axi_rlast;
    assign beat_err_s   = icache_m_axi_rresp != 2'b00;
    assign unused_s     = ^{icache_m_axi_rid, fetch_addr[1:0]};

    // Tag compare across all ways; the fill victim is invalid, so it can never hit.
    always_comb begin
        hit_way_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec_s[w] = valid_r[w][fetch_idx_s] && (tag_mem_r[w][fetch_idx_s] == fetch_tag_s);
            // At most one way matches, so OR-ing the way numbers yields the hit way.
            hit_way_s    = hit_way_s | (hit_vec_s[w] ? WAY_W'(w) : '0);
        end
        hit_s = |hit_vec_s;
    end

    // Victim: lowest-numbered invalid way, otherwise the set's round-robin pointer.
    always_comb begin
        victim_s = rr_r[fetch_idx_s];
        for (int w = WAYS - 1; w >= 0; w--) begin
            victim_s = valid_r[w][fetch_idx_s] ? victim_s : WAY_W'(w);
        end
    end

    // Read the hit word and pick the 32-bit half selected by address bit 2.
    always_comb begin
        word_s   = data_mem_r[hit_way_s][{fetch_idx_s, fetch_off_s}];
        out_inst = fetch_addr[2] ? word_s[63:32] : word_s[31:0];
    end

    assign icache_valid = hit_s;
    assign icache_err   = err_pulse_r;

    assign icache_m_axi_arid    = {ID_WIDTH{1'b0}};
    assign icache_m_axi_araddr  = {miss_addr_r, 3'b000};
    assign icache_m_axi_arlen   = 8'(LINE_WORDS - 1);
    assign icache_m_axi_arsize  = 3'b011;
    assign icache_m_axi_arburst = 2'b10;
    assign icache_m_axi_arlock  = 1'b0;
    assign icache_m_axi_arcache = 4'b0000;
    assign icache_m_axi_arprot  = 3'b110;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next state and channel handshake outputs.
    always_comb begin
        state_nx_s           = state_r;
        icache_m_axi_arvalid = 1'b0;
        icache_m_axi_rready  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!hit_s && !flush) begin
                    state_nx_s = ADDR;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ADDR: begin
                icache_m_axi_arvalid = 1'b1;
                if (icache_m_axi_arready) begin
                    state_nx_s = DATA;
                end else begin
                    state_nx_s = ADDR;
                end
            end
            DATA: begin
                icache_m_axi_rready = 1'b1;
                if (icache_m_axi_rvalid && icache_m_axi_rlast) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DATA;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Fill control: miss capture, valid bits, round-robin pointers, error and flush tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_r[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) begin
                rr_r[s] <= '0;
            end
            miss_addr_r  <= '0;
            victim_r     <= '0;
            fill_off_r   <= '0;
            err_r        <= 1'b0;
            flush_pend_r <= 1'b0;
            err_pulse_r  <= 1'b0;
        end else begin
            err_pulse_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    miss_addr_r <= fetch_addr[ADDR_WIDTH-1:3];
                    if (flush) begin
                        for (int w = 0; w < WAYS; w++) begin
                            valid_r[w] <= '0;
                        end
                    end else if (!hit_s) begin
                        victim_r                      <= victim_s;
                        valid_r[victim_s][fetch_idx_s] <= 1'b0;
                        fill_off_r                    <= fetch_off_s;
                        err_r                         <= 1'b0;
                        flush_pend_r                  <= 1'b0;
                    end
                end
                ADDR: begin
                    if (flush) begin
                        flush_pend_r <= 1'b1;
                    end
                end
                DATA: begin
                    if (flush) begin
                        flush_pend_r <= 1'b1;
                    end
                    if (beat_s) begin
                        fill_off_r <= fill_off_r + OFF_W'(1);
                        if (beat_err_s) begin
                            err_r <= 1'b1;
                        end
                    end
                    if (last_s) begin
                        rr_r[miss_idx_s] <= (rr_r[miss_idx_s] == WAY_W'(WAYS - 1)) ?
                                            '0 : rr_r[miss_idx_s] + WAY_W'(1);
                        err_pulse_r      <= err_r || beat_err_s;
                        err_r            <= 1'b0;
                        flush_pend_r     <= 1'b0;
                        // A flush seen at any point of the fill, including this beat, wins.
                        if (flush_pend_r || flush) begin
                            for (int w = 0; w < WAYS; w++) begin
                                valid_r[w] <= '0;
                            end
                        end else if (!(err_r || beat_err_s)) begin
                            valid_r[victim_r][miss_idx_s] <= 1'b1;
                        end
                    end
                end
                default: begin
                    err_r <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data arrays; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (start_fill_s) begin
            tag_mem_r[victim_s][fetch_idx_s] <= fetch_tag_s;
        end
        if (beat_s) begin
            data_mem_r[victim_r][{miss_idx_s, fill_off_r}] <= icache_m_axi_rdata;
        end
    end

endmodule
